// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch front end.
//   fetch_state_e : request/response sequencer states.
//   RESET_PC      : PC value forced by reset (all zeros); sliced to the
//                   address width by users.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fetch_state_e;

  localparam logic [63:0] RESET_PC = '0;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry instruction buffer holding {pc, instr} pairs.
// Ports:
//   clk, rst_n              clock, async active-low reset (clears storage)
//   push, push_pc/push_data write an entry at the tail
//   pop                     retire the head entry
//   flush                   empty the buffer (wins over push/pop)
//   count                   occupancy, 0..2
//   head_pc, head_data      current head entry
module fetch_fifo #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [ADDRESS_WIDTH-1:0] push_pc,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [1:0]               count,
  output logic [ADDRESS_WIDTH-1:0] head_pc,
  output logic [DATA_WIDTH-1:0]    head_data
);

  logic [ADDRESS_WIDTH-1:0] pc_mem   [2];
  logic [DATA_WIDTH-1:0]    data_mem [2];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic                     do_push;
  logic                     do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // When full, a push is only accepted alongside a pop; the write then
  // lands in the slot the head is vacating, so ordering is preserved.
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]   <= push_pc;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_pc   = pc_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC register, single-outstanding instruction-memory sequencer and
// a two-entry buffer towards decode.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   trigger                           fetch enable
//   next_pc                           sequential next PC (from pc_mux)
//   redirect, redirect_pc             taken branch/jump and its target
//   pc                                current fetch PC
//   imem_req_valid/ready/addr         instruction-memory request channel
//   imem_rsp_valid/data               single-cycle memory response
//   out_valid/ready, out_instr/out_pc buffered instruction to decode
module pc_fetch
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trigger,
  input  logic [ADDRESS_WIDTH-1:0] next_pc,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc
);

  localparam logic [1:0] FULL_COUNT = FIFO_DEPTH[1:0];

  fetch_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] req_pc_q;
  logic                     discard_q, discard_d;
  logic [1:0]               count;
  logic [1:0]               count_after;
  logic                     hs;
  logic                     push;
  logic                     pop;

  assign hs    = imem_req_valid && imem_req_ready;
  // Responses only count in WAIT; a redirect flushes whatever would land.
  assign push  = (state_q == WAIT) && imem_rsp_valid && !discard_q && !redirect;
  assign pop   = out_valid && out_ready && !redirect;
  assign count_after = count + {1'b0, push} - {1'b0, pop};

  // A request still owed by memory after a redirect blocks new requests
  // until it returns, keeping at most one in flight.
  assign imem_req_valid = (state_q == REQ) && trigger && (count != FULL_COUNT) && !discard_q;
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign out_valid      = (count != 2'd0);

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    if (discard_q && imem_rsp_valid) discard_d = 1'b0;
    case (state_q)
      IDLE: if (trigger) state_d = REQ;
      REQ: begin
        if (!trigger)                 state_d = IDLE;
        else if (count == FULL_COUNT) state_d = FULL;
        else if (hs)                  state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (count_after == FULL_COUNT) state_d = FULL;
          else if (trigger)              state_d = REQ;
          else                           state_d = IDLE;
        end
      end
      FULL: if (count_after != FULL_COUNT) state_d = trigger ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      state_d = trigger ? REQ : IDLE;
      // Anything memory still owes us (pending WAIT, or a request that
      // handshakes this very cycle) must be dropped when it returns.
      if (((state_q == WAIT) && !imem_rsp_valid) || hs) discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC[ADDRESS_WIDTH-1:0];
      req_pc_q  <= RESET_PC[ADDRESS_WIDTH-1:0];
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (redirect)  pc_q <= redirect_pc;
      else if (hs)   pc_q <= next_pc;
      // Tag for the in-flight instruction; pc_q has already moved on.
      if (hs) req_pc_q <= pc_q;
    end
  end

  fetch_fifo #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_pc  (req_pc_q),
    .push_data(imem_rsp_data),
    .pop      (pop),
    .flush    (redirect),
    .count    (count),
    .head_pc  (out_pc),
    .head_data(out_instr)
  );

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed scenarios plus a randomized run. A transaction-level
// model tracks the PC stream the core should see: requests and delivered
// instructions advance by 4 and restart at redirect_pc on a redirect; each
// instruction must carry the memory word of its own address.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        trigger = 1'b0;
  logic [31:0] next_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int          checks = 0;
  int          errors = 0;
  int          pend = 0;
  int          pend_lat = 0;
  int          lat = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_req = '0;
  logic [31:0] hs_log [$];
  logic [31:0] out_log [$];

  always #5 clk = ~clk;
  assign next_pc = pc + 32'd4;

  pc_fetch #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .next_pc(next_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc(pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, update the model, clock, then
  // play the memory side (fixed latency per request, one-cycle response).
  task automatic tick();
    logic        hs, pop, rd;
    logic [31:0] ha;
    #4;
    hs  = imem_req_valid && imem_req_ready;
    ha  = imem_req_addr;
    rd  = redirect;
    pop = out_valid && out_ready && !rd;
    if (pop) begin
      chk("out_pc", out_pc, exp_pc);
      chk("out_instr", out_instr, mem_word(out_pc));
      out_log.push_back(out_pc);
      exp_pc = exp_pc + 32'd4;
    end
    if (hs) begin
      chk("one_outstanding", pend, 0);
      if (!rd) begin
        chk("req_addr", ha, exp_req);
        hs_log.push_back(ha);
        exp_req = exp_req + 32'd4;
      end
    end
    if (rd) begin
      exp_pc  = redirect_pc;
      exp_req = redirect_pc;
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (hs) begin
      pend      = 1;
      pend_addr = ha;
      pend_lat  = lat;
    end
    if (pend == 1) begin
      if (pend_lat == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 0;
      end else begin
        pend_lat--;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    pend = 0;
    imem_rsp_valid = 1'b0;
    exp_pc  = '0;
    exp_req = '0;
    hs_log.delete();
    out_log.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, m;
    logic [31:0] a, p;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    do_reset();

    // Straight-line fetch with a 1-cycle memory
    trigger = 1'b1; out_ready = 1'b1; lat = 0;
    repeat (12) tick();
    chk("seq_hs_count", hs_log.size() >= 3, 1);
    chk("seq_addr0", hs_log[0], 32'h0);
    chk("seq_addr1", hs_log[1], 32'h4);
    chk("seq_addr2", hs_log[2], 32'h8);
    chk("seq_out_count", out_log.size() >= 3, 1);
    chk("seq_out0", out_log[0], 32'h0);
    chk("seq_out1", out_log[1], 32'h4);
    chk("seq_out2", out_log[2], 32'h8);

    // Back-pressure fills the buffer and stalls the PC
    do_reset();
    out_ready = 1'b0;
    repeat (10) tick();
    chk("full_req_valid", imem_req_valid, 0);
    chk("full_pc", pc, 32'h8);
    chk("full_out_valid", out_valid, 1);
    chk("full_out_pc", out_pc, 32'h0);
    chk("full_hs_count", hs_log.size(), 2);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("resume_pop0", out_log[0], 32'h0);
    chk("resume_hs_count", hs_log.size() >= 3, 1);
    chk("resume_addr", hs_log[2], 32'h8);

    // Redirect while waiting on the response for 0x10
    do_reset();
    out_ready = 1'b1; lat = 2;
    for (int i = 0; i < 100 && hs_log.size() < 5; i++) tick();
    chk("redir_reach", hs_log.size(), 5);
    chk("redir_wait_addr", hs_log[4], 32'h10);
    redirect = 1'b1; redirect_pc = 32'h100;
    n = hs_log.size(); m = out_log.size();
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 100 && (out_log.size() <= m || hs_log.size() <= n); i++) tick();
    chk("redir_progress", (out_log.size() > m) && (hs_log.size() > n), 1);
    chk("redir_next_addr", hs_log[n], 32'h100);
    chk("redir_first_out", out_log[m], 32'h100);

    // Memory not ready: request held steady
    lat = 0;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
    chk("stall_valid0", imem_req_valid, 1);
    a = imem_req_addr; p = pc;
    repeat (3) begin
      tick();
      chk("stall_valid", imem_req_valid, 1);
      chk("stall_addr", imem_req_addr, a);
      chk("stall_pc", pc, p);
    end
    imem_req_ready = 1'b1;
    repeat (6) tick();

    // Simultaneous pop and push keeps order
    do_reset();
    out_ready = 1'b0; lat = 1;
    for (int i = 0; i < 50 && hs_log.size() < 2; i++) tick();
    for (int i = 0; i < 10 && !imem_rsp_valid; i++) tick();
    chk("pp_rsp_pending", imem_rsp_valid, 1);
    chk("pp_pre_out_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pp_popped", out_log.size(), 1);
    chk("pp_out_valid", out_valid, 1);
    chk("pp_out_pc", out_pc, 32'h4);
    chk("pp_out_instr", out_instr, mem_word(32'h4));

    // Reset in the middle of WAIT with one buffered entry
    do_reset();
    out_ready = 1'b0; lat = 3;
    for (int i = 0; i < 50 && hs_log.size() < 2; i++) tick();
    chk("mid_pre_count1", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_pc", pc, 0);
    chk("mid_req_valid", imem_req_valid, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_out_instr", out_instr, 0);
    chk("mid_out_pc", out_pc, 0);
    do_reset();
    out_ready = 1'b1; lat = 0;
    for (int i = 0; i < 20 && hs_log.size() < 1; i++) tick();
    chk("mid_first_addr", hs_log[0], 32'h0);
    repeat (5) tick();

    // Randomized traffic against the stream model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      trigger        = ($urandom_range(0, 9) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      lat            = $urandom_range(0, 3);
      redirect       = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF8;
      else                           redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      tick();
    end
    redirect = 1'b0;
    chk("rand_progress", out_log.size() > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
